// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer:
// MIPS R-type funct codes and the sequencer FSM encodings.
package muldiv_sequencer_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide
// over a shared {hi,lo} accumulator. o_next_* is the result of the next step.
module muldiv_core #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  output logic [NB_DATA-1:0] o_next_hi,
  output logic [NB_DATA-1:0] o_next_lo
);

  logic [NB_DATA-1:0] r_acc_hi;
  logic [NB_DATA-1:0] r_acc_lo;
  logic [NB_DATA-1:0] r_operand;
  logic               r_is_div;

  logic [NB_DATA:0]   w_sum;
  logic [NB_DATA:0]   w_shift;
  logic [NB_DATA+1:0] w_diff;

  assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_operand} : '0);
  assign w_shift = {r_acc_hi, r_acc_lo[NB_DATA-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_operand};

  // Multiply: hi accumulates, product shifts down into lo.
  // Divide: lo holds the dividend shifting out and the quotient shifting in.
  always_comb begin
    o_next_hi = r_acc_hi;
    o_next_lo = r_acc_lo;
    if (r_is_div) begin
      if (!w_diff[NB_DATA+1]) begin
        o_next_hi = w_diff[NB_DATA-1:0];
        o_next_lo = {r_acc_lo[NB_DATA-2:0], 1'b1};
      end else begin
        o_next_hi = w_shift[NB_DATA-1:0];
        o_next_lo = {r_acc_lo[NB_DATA-2:0], 1'b0};
      end
    end else begin
      o_next_hi = w_sum[NB_DATA:1];
      o_next_lo = {w_sum[0], r_acc_lo[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_operand <= '0;
      r_is_div  <= 1'b0;
    end else if (i_load) begin
      r_acc_hi  <= '0;
      r_acc_lo  <= i_is_div ? i_op_a : i_op_b;
      r_operand <= i_is_div ? i_op_b : i_op_a;
      r_is_div  <= i_is_div;
    end else if (i_step) begin
      r_acc_hi  <= o_next_hi;
      r_acc_lo  <= o_next_lo;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning architectural HI/LO and the pipeline stall.
// Build option: define MULDIV_SIGNED_EN for signed MULT/DIV (otherwise they act as MULTU/DIVU).
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_FCODE = 6,
  parameter int NB_CNT   = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_FCODE-1:0] i_funct_code,
  input  logic [NB_DATA-1:0]  i_rs_data,
  input  logic [NB_DATA-1:0]  i_rt_data,
  input  logic                i_flush,
  output logic                o_stall,
  output logic                o_done,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo,
  output logic [NB_DATA-1:0]  o_mf_data,
  output logic                o_div_by_zero,
  output logic [1:0]          o_dbg_state
);

  logic [1:0]         r_state;
  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_DATA-1:0] r_hi;
  logic [NB_DATA-1:0] r_lo;
  logic               r_dbz;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mthi;
  logic               w_is_mtlo;
  logic               w_is_mfhi;
  logic               w_is_mflo;
  logic               w_busy;
  logic               w_last;
  logic               w_dbz;
  logic               w_load;
  logic [NB_DATA-1:0] w_op_a;
  logic [NB_DATA-1:0] w_op_b;
  logic [NB_DATA-1:0] w_core_hi;
  logic [NB_DATA-1:0] w_core_lo;
  logic [NB_DATA-1:0] w_res_hi;
  logic [NB_DATA-1:0] w_res_lo;

  assign w_is_mul  = i_valid && (i_funct_code == NB_FCODE'(FN_MULT) ||
                                 i_funct_code == NB_FCODE'(FN_MULTU));
  assign w_is_div  = i_valid && (i_funct_code == NB_FCODE'(FN_DIV) ||
                                 i_funct_code == NB_FCODE'(FN_DIVU));
  assign w_is_mthi = i_valid && i_funct_code == NB_FCODE'(FN_MTHI);
  assign w_is_mtlo = i_valid && i_funct_code == NB_FCODE'(FN_MTLO);
  assign w_is_mfhi = i_valid && i_funct_code == NB_FCODE'(FN_MFHI);
  assign w_is_mflo = i_valid && i_funct_code == NB_FCODE'(FN_MFLO);

  assign w_busy = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_last = (r_cnt == NB_CNT'(NB_DATA - 1));
  assign w_dbz  = w_is_div && (i_rt_data == '0);
  assign w_load = (r_state == ST_IDLE) && !i_flush && (w_is_mul || (w_is_div && !w_dbz));

`ifdef MULDIV_SIGNED_EN
  logic                 w_signed_op;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [2*NB_DATA-1:0] w_prod;

  assign w_signed_op = i_funct_code == NB_FCODE'(FN_MULT) || i_funct_code == NB_FCODE'(FN_DIV);
  assign w_op_a = (w_signed_op && i_rs_data[NB_DATA-1]) ? -i_rs_data : i_rs_data;
  assign w_op_b = (w_signed_op && i_rt_data[NB_DATA-1]) ? -i_rt_data : i_rt_data;
  assign w_prod = {w_core_hi, w_core_lo};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_load) begin
      r_neg_res <= w_signed_op && (i_rs_data[NB_DATA-1] ^ i_rt_data[NB_DATA-1]);
      r_neg_rem <= w_signed_op && i_rs_data[NB_DATA-1];
    end
  end

  // Remainder follows the dividend sign; product/quotient follow the sign XOR.
  always_comb begin
    w_res_hi = w_core_hi;
    w_res_lo = w_core_lo;
    if (r_state == ST_DIV) begin
      w_res_lo = r_neg_res ? -w_core_lo : w_core_lo;
      w_res_hi = r_neg_rem ? -w_core_hi : w_core_hi;
    end else if (r_neg_res) begin
      {w_res_hi, w_res_lo} = -w_prod;
    end
  end
`else
  assign w_op_a   = i_rs_data;
  assign w_op_b   = i_rt_data;
  assign w_res_hi = w_core_hi;
  assign w_res_lo = w_core_lo;
`endif

  muldiv_core #(
    .NB_DATA (NB_DATA)
  ) u_core (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_step    (w_busy && !i_flush),
    .i_is_div  (w_is_div),
    .i_op_a    (w_op_a),
    .i_op_b    (w_op_b),
    .o_next_hi (w_core_hi),
    .o_next_lo (w_core_lo)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul || w_is_div) begin
            r_cnt <= '0;
            if (w_dbz) begin
              r_state <= ST_DONE;
              r_hi    <= i_rs_data;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= w_is_mul ? ST_MUL : ST_DIV;
              r_dbz   <= 1'b0;
            end
          end else begin
            if (w_is_mthi) r_hi <= i_rs_data;
            if (w_is_mtlo) r_lo <= i_rs_data;
          end
        end
        ST_MUL, ST_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_dbz   <= 1'b0;
          if (w_is_mthi) r_hi <= i_rs_data;
          if (w_is_mtlo) r_lo <= i_rs_data;
        end
      endcase
    end
  end

  // Stall covers the accepting cycle and every iteration; DONE releases the pipe.
  assign o_stall = !i_reset &&
                   (w_busy || ((r_state == ST_IDLE) && !i_flush && (w_is_mul || w_is_div)));
  assign o_done        = (r_state == ST_DONE);
  assign o_div_by_zero = r_dbz && (r_state == ST_DONE);
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_mf_data     = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : '0);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized scoreboard bench for muldiv_sequencer against an arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [5:0]  i_funct_code = '0;
  logic [31:0] i_rs_data = '0;
  logic [31:0] i_rt_data = '0;
  logic        i_flush = 1'b0;
  logic        o_stall, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo, o_mf_data;
  logic [1:0]  o_dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [64:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_sequencer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_funct_code  (i_funct_code),
    .i_rs_data     (i_rs_data),
    .i_rt_data     (i_rt_data),
    .i_flush       (i_flush),
    .o_stall       (o_stall),
    .o_done        (o_done),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_mf_data     (o_mf_data),
    .o_div_by_zero (o_div_by_zero),
    .o_dbg_state   (o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {div_by_zero, HI, LO} from plain arithmetic on the operands.
  function automatic logic [64:0] model(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic   is_div, sgn;
    longint sa, sb, q, r, p;
    logic [63:0] up;
    is_div = (fn == F_DIV) || (fn == F_DIVU);
`ifdef MULDIV_SIGNED_EN
    sgn = (fn == F_MULT) || (fn == F_DIV);
`else
    sgn = 1'b0;
`endif
    sa = $signed(a);
    sb = $signed(b);
    if (is_div && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (!is_div) begin
      if (sgn) begin
        p = sa * sb;
        return {1'b0, p[63:0]};
      end
      up = {32'd0, a} * {32'd0, b};
      return {1'b0, up};
    end
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    return {1'b0, a % b, a / b};
  endfunction

  // Monitor: every o_done pulse must match the oldest outstanding expectation.
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge i_clk);
      #2;
      if (o_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_done: got o_done=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("done_result", {31'd0, o_div_by_zero, o_hi, o_lo}, {31'd0, e});
        end
      end
    end
  end

  // One muldiv op; mf_at/flush_at/reset_at = cycle to inject MFLO / flush / reset (-1 = never).
  task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input int mf_at, input int flush_at, input int reset_at);
    logic [64:0] e;
    int lim, last, first_done, stall_err;
    e = model(fn, a, b);
    lim = e[64] ? 1 : 33;
    if (flush_at >= 0) lim = flush_at + 1;
    last = (flush_at >= 0) ? 39 : ((reset_at >= 0) ? reset_at : lim);
    if (flush_at < 0 && reset_at < 0) exp_q.push_back(e);
    first_done = -1;
    stall_err = 0;
    for (int k = 0; k <= last; k++) begin
      @(negedge i_clk);
      i_rs_data = a;
      i_rt_data = b;
      i_flush   = (k == flush_at);
      i_reset   = (k == reset_at);
      if (k == 0) begin
        i_valid = 1'b1;
        i_funct_code = fn;
      end else if (mf_at >= 0 && k >= mf_at) begin
        i_valid = 1'b1;
        i_funct_code = F_MFLO;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (k == reset_at) begin
        check("reset_hi", o_hi, 0);
        check("reset_lo", o_lo, 0);
        check("reset_done_stall", {o_done, o_stall, o_div_by_zero}, 0);
        check("reset_state", o_dbg_state, 0);
      end else begin
        if (o_stall !== (k < lim)) stall_err++;
        if (o_done === 1'b1 && first_done < 0) first_done = k;
        if (k == flush_at + 1) begin
          check("flush_idle", o_dbg_state, 0);
          check("flush_hilo", {o_hi, o_lo}, {m_hi, m_lo});
        end
        if (mf_at >= 0 && k == lim) check("mflo_after_stall", o_mf_data, e[31:0]);
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_reset = 1'b0;
    check("stall_profile_errors", stall_err, 0);
    if (flush_at >= 0 || reset_at >= 0) begin
      check("no_done_after_abort", first_done, -1);
      if (reset_at >= 0) begin
        m_hi = '0;
        m_lo = '0;
      end
    end else begin
      check("done_cycle", first_done, lim);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    #1;
    check("idle_hilo", {o_hi, o_lo}, {m_hi, m_lo});
  endtask

  task automatic do_simple(input logic [5:0] fn, input logic [31:0] v);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_funct_code = fn;
    i_rs_data = v;
    i_rt_data = ~v;
    #1;
    check("simple_stall", o_stall, 0);
    if (fn == F_MFHI) check("mfhi_data", o_mf_data, m_hi);
    else if (fn == F_MFLO) check("mflo_data", o_mf_data, m_lo);
    else check("mf_data_zero", o_mf_data, 0);
    if (fn == F_MTHI) m_hi = v;
    if (fn == F_MTLO) m_lo = v;
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    check("simple_hilo", {o_hi, o_lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [5:0]  ops[4];
    logic [5:0]  smp[5];
    logic [31:0] a, b;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    smp = '{F_MTHI, F_MTLO, F_MFHI, F_MFLO, F_ADD};

    i_valid = 1'b1;
    i_funct_code = F_MULTU;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_hilo", {o_hi, o_lo}, 0);
    check("rst_flags", {o_done, o_stall, o_div_by_zero}, 0);
    check("rst_state", o_dbg_state, 0);
    i_valid = 1'b0;
    i_reset = 1'b0;

    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    do_op(F_MULT, 32'hFFFF_FFFD, 32'd7, -1, -1, -1);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    do_op(F_DIVU, 32'd100, 32'd0, -1, -1, -1);
    do_op(F_MULTU, 32'd6, 32'd7, 5, -1, -1);
    check("mflo_6x7_value", m_lo, 32'h2A);
    do_simple(F_MTHI, 32'h1234_5678);
    do_simple(F_MTLO, 32'h9ABC_DEF0);
    do_simple(F_MFHI, 32'd0);
    do_simple(F_ADD, 32'h5555_AAAA);
    do_op(F_DIVU, 32'd1000, 32'd7, -1, 10, -1);
    do_op(F_MULT, 32'd123, 32'd456, -1, -1, 20);
    do_simple(F_MFLO, 32'd0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      do_op(ops[$urandom_range(0, 3)], a, b, -1, -1, -1);
      do_simple(smp[$urandom_range(0, 4)], $urandom);
    end

    repeat (4) @(negedge i_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
